imm_gen_pipe: RTL and testbench
===============================

// Module: imm_gen_pipe
// PURPOSE
//  Decoupled, parametrised immediate generator for the ID stage of the five-stage core.
//  Decodes the immediate, format and PC-relative target of each accepted instruction.
//  Results go through a DEPTH-entry FIFO with a valid/ready handshake, so IF/ID stalls do not
//  lose results. Feeds ALU operand mux, branch unit and jump-target logic.
// PARAMETERS
//  XLEN   32  datapath width; 32 or 64 only
//  DEPTH  2   result FIFO entries; power of two, >= 2
// PORTS
//  clk          in   1     single clock; all state updates on posedge
//  rst          in   1     synchronous, active-high reset
//  flush        in   1     pipeline flush (branch mispredict / trap); sync, drops all entries
//  in_valid     in   1     in_instr/in_pc valid
//  in_ready     out  1     FIFO can accept; registered, = !full
//  in_instr     in   32    raw instruction word
//  in_pc        in   XLEN  PC of in_instr
//  out_valid    out  1     head entry valid; = !empty
//  out_ready    in   1     consumer takes head this cycle
//  out_imm      out  XLEN  sign/zero-extended immediate
//  out_fmt      out  3     IMM_NONE=0, IMM_I=1, IMM_S=2, IMM_B=3, IMM_U=4, IMM_J=5
//  out_target   out  XLEN  in_pc + out_imm, modulo 2^XLEN
//  out_illegal  out  1     only when IMM_GEN_ILLEGAL_EN is defined
// BEHAVIOUR
//  Reset: FIFO empty, in_ready=1, out_valid=0. out_imm/out_fmt/out_target/out_illegal read 0 when empty.
//  Push when in_valid&&in_ready; pop when out_valid&&out_ready. Decode is combinational on input.
//  Latency 1: accepted at edge N, visible at head after edge N (if FIFO was empty). Order is FIFO.
//  Full: in_ready=0 even if a pop happens the same cycle (registered ready); next cycle in_ready=1.
//  Empty + push: no same-cycle bypass; out_valid rises after the edge.
//  Push+pop, neither full nor empty: count unchanged, both pointers advance; wrap at DEPTH.
//  flush or rst: pointers/count cleared at the edge. A push or pop in that cycle is discarded.
//    rst has priority over flush.
//  Decode by opcode (constants from riscv.v):
//    Jalr, Il_Type, I_Type, SYSTEM(1110011) -> I: sext(instr[31:20])
//    I_Type funct3 001/101 -> I, zero-ext shamt: instr[24:20] (XLEN=32), instr[25:20] (XLEN=64)
//    S_Type -> S: sext({instr[31:25],instr[11:7]})
//    B_Type -> B: sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0})
//    lui, auipc -> U: sext({instr[31:12],12'b0}) to XLEN
//    Jal -> J: sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0})
//    other opcodes (R-type etc.) -> IMM_NONE, imm=0
//  out_target is always in_pc+imm, computed before the FIFO write and stored per entry.
// CONFIGURATION
//  IMM_GEN_ILLEGAL_EN defined: out_illegal port exists.
//    out_illegal=1 when instr[1:0]!=2'b11 or the opcode is not in the table above or R/OP;
//    fmt=IMM_NONE, imm=0; the entry is still queued.
//  Not defined: port and storage absent; unknown opcodes decode to IMM_NONE, imm=0 silently.
// STRUCTURE
//  riscv.v (shared header): opcode constants (existing) plus the IMM_* format codes and
//    OP_SYSTEM / OP_R.
//  One sub-module: imm_decode (pure combinational, instr -> imm, fmt, illegal; parametrised by XLEN).
//  Top level: imm_decode, target adder, DEPTH-entry FIFO (storage, wr/rd pointers, count).
// TESTING
//  1 addi x1,x0,-1 (0xFFF00093), pc=0 -> next cycle out_valid=1, imm=0xFFFFFFFF, fmt=I,
//    target=0xFFFFFFFF.
//  2 slli x1,x1,31 (0x01F09093) -> imm=31, fmt=I.
//    sw x2,33(x1) (0x0220A0A3) -> imm=33, fmt=S.
//  3 beq (0x02208163), pc=0x100 -> imm=34, fmt=B, target=0x122.
//    jal x0,-4 (0xFFDFF06F), pc=0x200 -> imm=0xFFFFFFFC, fmt=J, target=0x1FC.
//  4 XLEN=64: lui (0x800000B7) -> imm=0xFFFFFFFF80000000, fmt=U.
//    lui 0x12345 (0x123450B7) -> imm=0x12345000.
//  5 DEPTH=2, out_ready=0, three back-to-back pushes -> in_ready=0 after the 2nd push, 3rd held.
//    Raise out_ready -> results in order; in_ready returns 1 the cycle after the first pop.
//  6 FIFO holds 2 entries, flush with in_valid=1 -> next cycle out_valid=0, count=0, pushed
//    instr absent. Repeat with rst mid-stream -> same.
//    IMM_GEN_ILLEGAL_EN: 0x00000000 -> out_illegal=1, fmt=NONE.

Source files
------------

// File: rtl/imm_gen_pipe_pkg.sv
// Shared RISC-V decode constants for the ID-stage immediate generator:
// opcode values, immediate format codes and a small funct3 helper.
package imm_gen_pipe_pkg;

   localparam logic [6:0] OP_IL_TYPE = 7'b0000011;
   localparam logic [6:0] OP_I_TYPE  = 7'b0010011;
   localparam logic [6:0] OP_AUIPC   = 7'b0010111;
   localparam logic [6:0] OP_S_TYPE  = 7'b0100011;
   localparam logic [6:0] OP_R       = 7'b0110011;
   localparam logic [6:0] OP_LUI     = 7'b0110111;
   localparam logic [6:0] OP_B_TYPE  = 7'b1100011;
   localparam logic [6:0] OP_JALR    = 7'b1100111;
   localparam logic [6:0] OP_JAL     = 7'b1101111;
   localparam logic [6:0] OP_SYSTEM  = 7'b1110011;

   typedef enum logic [2:0] {
      IMM_NONE = 3'd0,
      IMM_I    = 3'd1,
      IMM_S    = 3'd2,
      IMM_B    = 3'd3,
      IMM_U    = 3'd4,
      IMM_J    = 3'd5
   } imm_fmt_e;

   // Shift-immediate ops (slli/srli/srai) carry a zero-extended shamt, not a signed imm.
   function automatic logic is_shift_funct3(input logic [2:0] funct3);
      return (funct3 == 3'b001) || (funct3 == 3'b101);
   endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate/format decode of one instruction word.
// IMM_GEN_ILLEGAL_EN adds the illegal output for unknown opcodes.
module imm_decode
   import imm_gen_pipe_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     instr,
   output logic [XLEN-1:0] imm,
   output logic [2:0]      fmt
`ifdef IMM_GEN_ILLEGAL_EN
   ,
   output logic            illegal
`endif
);

   localparam int SHW = (XLEN == 64) ? 6 : 5;

   logic [6:0]         opcode;
   logic [2:0]         funct3;
   logic signed [31:0] imm_i;
   logic signed [31:0] imm_s;
   logic signed [31:0] imm_b;
   logic signed [31:0] imm_u;
   logic signed [31:0] imm_j;
   logic [XLEN-1:0]    shamt;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];

   // All formats are built as signed 32-bit values, then sign-extended to XLEN by the cast.
   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u = {instr[31:12], 12'b0};
   assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
   assign shamt = XLEN'(instr[20 +: SHW]);

   always_comb begin
      imm = '0;
      fmt = IMM_NONE;
      case (opcode)
         OP_JALR, OP_IL_TYPE, OP_SYSTEM: begin
            imm = XLEN'(imm_i);
            fmt = IMM_I;
         end
         OP_I_TYPE: begin
            imm = is_shift_funct3(funct3) ? shamt : XLEN'(imm_i);
            fmt = IMM_I;
         end
         OP_S_TYPE: begin
            imm = XLEN'(imm_s);
            fmt = IMM_S;
         end
         OP_B_TYPE: begin
            imm = XLEN'(imm_b);
            fmt = IMM_B;
         end
         OP_LUI, OP_AUIPC: begin
            imm = XLEN'(imm_u);
            fmt = IMM_U;
         end
         OP_JAL: begin
            imm = XLEN'(imm_j);
            fmt = IMM_J;
         end
         default: begin
            imm = '0;
            fmt = IMM_NONE;
         end
      endcase
   end

`ifdef IMM_GEN_ILLEGAL_EN
   always_comb begin
      illegal = 1'b1;
      case (opcode)
         OP_JALR, OP_IL_TYPE, OP_SYSTEM, OP_I_TYPE, OP_S_TYPE, OP_B_TYPE,
         OP_LUI, OP_AUIPC, OP_JAL, OP_R:
            illegal = (instr[1:0] != 2'b11);
         default:
            illegal = 1'b1;
      endcase
   end
`endif

endmodule

// File: rtl/imm_gen_pipe.sv
// ID-stage immediate generator: decode + PC-relative target, queued in a DEPTH-entry FIFO
// with valid/ready on both sides. IMM_GEN_ILLEGAL_EN adds the out_illegal port.
module imm_gen_pipe
   import imm_gen_pipe_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_imm,
   output logic [2:0]      out_fmt,
   output logic [XLEN-1:0] out_target
`ifdef IMM_GEN_ILLEGAL_EN
   ,
   output logic            out_illegal
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [XLEN-1:0] dec_imm;
   logic [2:0]      dec_fmt;
   logic [XLEN-1:0] dec_target;

   logic [XLEN-1:0] imm_mem [DEPTH];
   logic [2:0]      fmt_mem [DEPTH];
   logic [XLEN-1:0] tgt_mem [DEPTH];

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] count_nxt;
   logic          push;
   logic          pop;

`ifdef IMM_GEN_ILLEGAL_EN
   logic             dec_illegal;
   logic [DEPTH-1:0] ill_mem;
`endif

   imm_decode #(
      .XLEN (XLEN)
   ) u_decode (
      .instr   (in_instr),
      .imm     (dec_imm),
      .fmt     (dec_fmt)
`ifdef IMM_GEN_ILLEGAL_EN
      ,
      .illegal (dec_illegal)
`endif
   );

   assign dec_target = in_pc + dec_imm;

   assign push = in_valid && in_ready;
   assign pop  = out_valid && out_ready;

   always_comb begin
      count_nxt = count;
      if (push && !pop) begin
         count_nxt = count + CW'(1);
      end else if (pop && !push) begin
         count_nxt = count - CW'(1);
      end
   end

   // in_ready is registered from the next count, so a pop into a full FIFO frees it a cycle later.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         in_ready <= 1'b1;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count    <= count_nxt;
         in_ready <= (count_nxt != CW'(DEPTH));
      end
   end

   always_ff @(posedge clk) begin
      if (push && !rst && !flush) begin
         imm_mem[wr_ptr] <= dec_imm;
         fmt_mem[wr_ptr] <= dec_fmt;
         tgt_mem[wr_ptr] <= dec_target;
      end
   end

   assign out_valid  = (count != '0);
   assign out_imm    = out_valid ? imm_mem[rd_ptr] : '0;
   assign out_fmt    = out_valid ? fmt_mem[rd_ptr] : IMM_NONE;
   assign out_target = out_valid ? tgt_mem[rd_ptr] : '0;

`ifdef IMM_GEN_ILLEGAL_EN
   always_ff @(posedge clk) begin
      if (push && !rst && !flush) begin
         ill_mem[wr_ptr] <= dec_illegal;
      end
   end

   assign out_illegal = out_valid ? ill_mem[rd_ptr] : 1'b0;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share stimulus and are checked
// against an arithmetic decode model and a queue model of the FIFO.
module tb_imm_gen_pipe;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, out_ready;
   logic [31:0] in_instr;
   logic [63:0] in_pc;

   logic        r32, v32, r64, v64;
   logic [31:0] imm32, tgt32;
   logic [63:0] imm64, tgt64;
   logic [2:0]  fmt32, fmt64;
`ifdef IMM_GEN_ILLEGAL_EN
   logic        ill32, ill64;
`endif

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] instr;
      logic [63:0] pc;
   } ent_t;

   ent_t q[$];
   bit   m_ready = 1'b1;

   always #5 clk = ~clk;

   imm_gen_pipe #(.XLEN(32), .DEPTH(DEPTH)) u32 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(r32), .in_instr(in_instr), .in_pc(in_pc[31:0]),
      .out_valid(v32), .out_ready(out_ready),
      .out_imm(imm32), .out_fmt(fmt32), .out_target(tgt32)
`ifdef IMM_GEN_ILLEGAL_EN
      , .out_illegal(ill32)
`endif
   );

   imm_gen_pipe #(.XLEN(64), .DEPTH(DEPTH)) u64 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(r64), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(v64), .out_ready(out_ready),
      .out_imm(imm64), .out_fmt(fmt64), .out_target(tgt64)
`ifdef IMM_GEN_ILLEGAL_EN
      , .out_illegal(ill64)
`endif
   );

   // Reference decode: immediate value as a plain signed integer.
   function automatic logic [63:0] m_imm(input logic [31:0] w, input bit wide);
      longint v;
      v = 0;
      case (w[6:0])
         7'b1100111, 7'b0000011, 7'b1110011: v = $signed(w[31:20]);
         7'b0010011:
            if (w[14:12] == 3'b001 || w[14:12] == 3'b101)
               v = wide ? longint'(w[25:20]) : longint'(w[24:20]);
            else
               v = $signed(w[31:20]);
         7'b0100011: v = $signed({w[31:25], w[11:7]});
         7'b1100011: v = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0});
         7'b0110111, 7'b0010111: v = longint'($signed(w[31:12])) * 4096;
         7'b1101111: v = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0});
         default: v = 0;
      endcase
      return v;
   endfunction

   function automatic logic [2:0] m_fmt(input logic [31:0] w);
      case (w[6:0])
         7'b1100111, 7'b0000011, 7'b1110011, 7'b0010011: return 3'd1;
         7'b0100011: return 3'd2;
         7'b1100011: return 3'd3;
         7'b0110111, 7'b0010111: return 3'd4;
         7'b1101111: return 3'd5;
         default: return 3'd0;
      endcase
   endfunction

   function automatic logic m_ill(input logic [31:0] w);
      return (m_fmt(w) == 3'd0) && (w[6:0] != 7'b0110011);
   endfunction

   // Advance one clock and update the FIFO model; outputs are sampled 1 time unit after the edge.
   task automatic step();
      bit push, pop;
      push = in_valid && m_ready;
      pop  = (q.size() != 0) && out_ready;
      @(posedge clk);
      if (rst || flush) begin
         q.delete();
         m_ready = 1'b1;
      end else begin
         if (pop) void'(q.pop_front());
         if (push) q.push_back('{instr: in_instr, pc: in_pc});
         m_ready = (q.size() != DEPTH);
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
      in_instr = 32'hFFF00093; in_pc = 64'h0;
      step();
      step();
      rst = 1'b0; in_valid = 1'b0;
      checks++; if (r32 !== 1'b1 || r64 !== 1'b1) begin failures++;
         $display("FAIL reset_in_ready got=%b/%b exp=1", r32, r64); end
      checks++; if (v32 !== 1'b0 || v64 !== 1'b0) begin failures++;
         $display("FAIL reset_out_valid got=%b/%b exp=0", v32, v64); end
      checks++; if (imm32 !== 32'h0 || imm64 !== 64'h0 || fmt32 !== 3'd0 || fmt64 !== 3'd0) begin
         failures++; $display("FAIL reset_imm_fmt got=%h/%h/%0d/%0d exp=0", imm32, imm64, fmt32, fmt64); end
      checks++; if (tgt32 !== 32'h0 || tgt64 !== 64'h0) begin failures++;
         $display("FAIL reset_target got=%h/%h exp=0", tgt32, tgt64); end
`ifdef IMM_GEN_ILLEGAL_EN
      checks++; if (ill32 !== 1'b0 || ill64 !== 1'b0) begin failures++;
         $display("FAIL reset_illegal got=%b/%b exp=0", ill32, ill64); end
`endif
   endtask

   task automatic test_decode();
      logic [31:0] t_in  [14];
      logic [63:0] t_pc  [14];
      logic [31:0] t_i32 [14];
      logic [31:0] t_t32 [14];
      logic [63:0] t_i64 [14];
      logic [63:0] t_t64 [14];
      logic [2:0]  t_f   [14];
      logic        t_il  [14];
      t_in  = '{32'hFFF00093, 32'h01F09093, 32'h03F09093, 32'h4050D093, 32'h0220A0A3,
                32'h02208163, 32'hFFDFF06F, 32'h800000B7, 32'h123450B7, 32'hFFFFF097,
                32'h008100E7, 32'h003100B3, 32'h00000000, 32'h0000001B};
      t_pc  = '{64'h0, 64'h40, 64'h40, 64'h0, 64'h10, 64'h100, 64'h200, 64'h0, 64'h8,
                64'h2000, 64'h1000, 64'h300, 64'h44, 64'h4};
      t_i32 = '{32'hFFFFFFFF, 32'h1F, 32'h1F, 32'h5, 32'h21, 32'h22, 32'hFFFFFFFC,
                32'h80000000, 32'h12345000, 32'hFFFFF000, 32'h8, 32'h0, 32'h0, 32'h0};
      t_t32 = '{32'hFFFFFFFF, 32'h5F, 32'h5F, 32'h5, 32'h31, 32'h122, 32'h1FC,
                32'h80000000, 32'h12345008, 32'h1000, 32'h1008, 32'h300, 32'h44, 32'h4};
      t_i64 = '{64'hFFFFFFFFFFFFFFFF, 64'h1F, 64'h3F, 64'h5, 64'h21, 64'h22,
                64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFF80000000, 64'h12345000,
                64'hFFFFFFFFFFFFF000, 64'h8, 64'h0, 64'h0, 64'h0};
      t_t64 = '{64'hFFFFFFFFFFFFFFFF, 64'h5F, 64'h7F, 64'h5, 64'h31, 64'h122, 64'h1FC,
                64'hFFFFFFFF80000000, 64'h12345008, 64'h1000, 64'h1008, 64'h300, 64'h44, 64'h4};
      t_f   = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd3, 3'd5, 3'd4, 3'd4, 3'd4, 3'd1, 3'd0, 3'd0, 3'd0};
      t_il  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 14; i++) begin
         out_ready = 1'b0; in_valid = 1'b1; in_instr = t_in[i]; in_pc = t_pc[i];
         step();
         in_valid = 1'b0;
         checks++; if (v32 !== 1'b1 || v64 !== 1'b1) begin failures++;
            $display("FAIL dec%0d_valid got=%b/%b exp=1", i, v32, v64); end
         checks++; if (imm32 !== t_i32[i] || fmt32 !== t_f[i] || tgt32 !== t_t32[i]) begin failures++;
            $display("FAIL dec%0d_x32 got imm=%h fmt=%0d tgt=%h exp imm=%h fmt=%0d tgt=%h",
                     i, imm32, fmt32, tgt32, t_i32[i], t_f[i], t_t32[i]); end
         checks++; if (imm64 !== t_i64[i] || fmt64 !== t_f[i] || tgt64 !== t_t64[i]) begin failures++;
            $display("FAIL dec%0d_x64 got imm=%h fmt=%0d tgt=%h exp imm=%h fmt=%0d tgt=%h",
                     i, imm64, fmt64, tgt64, t_i64[i], t_f[i], t_t64[i]); end
`ifdef IMM_GEN_ILLEGAL_EN
         checks++; if (ill32 !== t_il[i] || ill64 !== t_il[i]) begin failures++;
            $display("FAIL dec%0d_illegal got=%b/%b exp=%b", i, ill32, ill64, t_il[i]); end
`endif
         out_ready = 1'b1;
         step();
         out_ready = 1'b0;
      end
      checks++; if (v32 !== 1'b0 || v64 !== 1'b0) begin failures++;
         $display("FAIL dec_drained got=%b/%b exp=0", v32, v64); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] seq [3];
      seq = '{32'hFFF00093, 32'h01F09093, 32'h0220A0A3};
      out_ready = 1'b0; in_valid = 1'b1; in_pc = 64'h0;
      in_instr = seq[0]; step();
      checks++; if (r32 !== 1'b1 || r64 !== 1'b1) begin failures++;
         $display("FAIL b2b_ready_after1 got=%b/%b exp=1", r32, r64); end
      in_instr = seq[1]; step();
      checks++; if (r32 !== 1'b0 || r64 !== 1'b0) begin failures++;
         $display("FAIL b2b_full got=%b/%b exp=0", r32, r64); end
      in_instr = seq[2]; step();
      checks++; if (r32 !== 1'b0 || imm32 !== 32'hFFFFFFFF) begin failures++;
         $display("FAIL b2b_held got ready=%b imm=%h exp ready=0 imm=ffffffff", r32, imm32); end
      out_ready = 1'b1; step();
      checks++; if (r32 !== 1'b1 || r64 !== 1'b1 || imm32 !== 32'd31 || fmt32 !== 3'd1) begin
         failures++; $display("FAIL b2b_first_pop got ready=%b/%b imm=%h fmt=%0d exp ready=1 imm=1f fmt=1",
                              r32, r64, imm32, fmt32); end
      step();
      checks++; if (imm32 !== 32'd33 || fmt32 !== 3'd2 || v32 !== 1'b1) begin failures++;
         $display("FAIL b2b_third got imm=%h fmt=%0d v=%b exp imm=21 fmt=2 v=1", imm32, fmt32, v32); end
      in_valid = 1'b0; step();
      checks++; if (v32 !== 1'b0 || v64 !== 1'b0) begin failures++;
         $display("FAIL b2b_empty got=%b/%b exp=0", v32, v64); end
      out_ready = 1'b0;
   endtask

   task automatic test_flush_rst();
      out_ready = 1'b0; in_valid = 1'b1; in_pc = 64'h80;
      in_instr = 32'hFFF00093; step();
      in_instr = 32'h01F09093; step();
      flush = 1'b1; in_instr = 32'h0220A0A3; step();
      flush = 1'b0; in_valid = 1'b0;
      checks++; if (v32 !== 1'b0 || v64 !== 1'b0 || r32 !== 1'b1 || r64 !== 1'b1) begin failures++;
         $display("FAIL flush_full got v=%b/%b r=%b/%b exp v=0 r=1", v32, v64, r32, r64); end
      in_valid = 1'b1; in_instr = 32'hFFF00093; step();
      flush = 1'b1; in_instr = 32'h02208163; out_ready = 1'b1; step();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; step();
      checks++; if (v32 !== 1'b0 || v64 !== 1'b0) begin failures++;
         $display("FAIL flush_push_dropped got=%b/%b exp=0", v32, v64); end
      in_valid = 1'b1; in_instr = 32'h02208163; in_pc = 64'h100; step();
      checks++; if (r32 !== 1'b1 || tgt32 !== 32'h122) begin failures++;
         $display("FAIL flush_count_cleared got r=%b tgt=%h exp r=1 tgt=122", r32, tgt32); end
      in_instr = 32'hFFDFF06F; step();
      checks++; if (r32 !== 1'b0 || tgt64 !== 64'h122) begin failures++;
         $display("FAIL flush_refill got r=%b tgt=%h exp r=0 tgt=122", r32, tgt64); end
      rst = 1'b1; in_instr = 32'h0220A0A3; out_ready = 1'b1; step();
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      checks++; if (v32 !== 1'b0 || v64 !== 1'b0 || r32 !== 1'b1 || r64 !== 1'b1) begin failures++;
         $display("FAIL rst_mid got v=%b/%b r=%b/%b exp v=0 r=1", v32, v64, r32, r64); end
      step();
      checks++; if (v32 !== 1'b0 || imm32 !== 32'h0) begin failures++;
         $display("FAIL rst_push_dropped got v=%b imm=%h exp v=0 imm=0", v32, imm32); end
   endtask

   task automatic test_random();
      logic [6:0]  ops [12];
      logic [63:0] e64, t64;
      logic [31:0] e32, t32;
      logic [2:0]  ef;
      ent_t        h;
      ops = '{7'b1100111, 7'b0000011, 7'b1110011, 7'b0010011, 7'b0100011, 7'b1100011,
              7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011, 7'b0011011, 7'b0001111};
      for (int c = 0; c < 800; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 39) == 0);
         rst       = ($urandom_range(0, 149) == 0);
         in_instr  = $urandom;
         if ($urandom_range(0, 7) != 0) in_instr[6:0] = ops[$urandom_range(0, 11)];
         in_pc = {$urandom, $urandom};
         step();
         checks++; if (v32 !== (q.size() != 0) || v64 !== (q.size() != 0)) begin failures++;
            $display("FAIL rnd%0d_valid got=%b/%b exp=%b", c, v32, v64, q.size() != 0); end
         checks++; if (r32 !== m_ready || r64 !== m_ready) begin failures++;
            $display("FAIL rnd%0d_ready got=%b/%b exp=%b", c, r32, r64, m_ready); end
         if (q.size() != 0) begin
            h   = q[0];
            ef  = m_fmt(h.instr);
            e64 = m_imm(h.instr, 1'b1);
            t64 = h.pc + e64;
            e32 = 32'(m_imm(h.instr, 1'b0));
            t32 = 32'(h.pc) + e32;
            checks++; if (imm32 !== e32 || fmt32 !== ef || tgt32 !== t32) begin failures++;
               $display("FAIL rnd%0d_x32 instr=%h got imm=%h fmt=%0d tgt=%h exp imm=%h fmt=%0d tgt=%h",
                        c, h.instr, imm32, fmt32, tgt32, e32, ef, t32); end
            checks++; if (imm64 !== e64 || fmt64 !== ef || tgt64 !== t64) begin failures++;
               $display("FAIL rnd%0d_x64 instr=%h got imm=%h fmt=%0d tgt=%h exp imm=%h fmt=%0d tgt=%h",
                        c, h.instr, imm64, fmt64, tgt64, e64, ef, t64); end
`ifdef IMM_GEN_ILLEGAL_EN
            checks++; if (ill32 !== m_ill(h.instr) || ill64 !== m_ill(h.instr)) begin failures++;
               $display("FAIL rnd%0d_illegal instr=%h got=%b/%b exp=%b",
                        c, h.instr, ill32, ill64, m_ill(h.instr)); end
`endif
         end
      end
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_instr = 32'h0; in_pc = 64'h0;
      test_reset();
      test_decode();
      test_back_to_back();
      test_flush_rst();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
